// File: rtl/wb_regfile.sv
// Writeback stage and 16 x 16-bit architectural register file for the five-stage pipeline.
// Selects the writeback value, commits it, and serves two bypassed decode read ports.
module wb_regfile #(
    parameter int NREG     = 16,
    parameter int DW       = 16,
    parameter int LINK_REG = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rf_wen_memwb,
    input  logic          mem2reg_memwb,
    input  logic          s7_memwb,
    input  logic          jal_memwb,
    input  logic          nop_lw_memwb,
    input  logic [3:0]    rf_waddr_memwb,
    input  logic [DW-1:0] aluout_memwb,
    input  logic [DW-1:0] extended_memwb,
    input  logic [DW-1:0] pc_added_memwb,
    input  logic [DW-1:0] mem_rdata,
    input  logic [3:0]    raddr1,
    input  logic [3:0]    raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic          fwd_valid,
    output logic [3:0]    fwd_addr,
    output logic [DW-1:0] fwd_data,
    output logic [15:0]   wb_count
);

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] wb_data;
    logic [3:0]    waddr_eff;
    logic          wen_eff;

    always_comb begin
        if (jal_memwb)
            wb_data = pc_added_memwb;
        else if (mem2reg_memwb)
            wb_data = mem_rdata;
        else if (s7_memwb)
            wb_data = extended_memwb;
        else
            wb_data = aluout_memwb;
    end

    assign waddr_eff = jal_memwb ? 4'(LINK_REG) : rf_waddr_memwb;

    // Qualified by rst_n so the bypass and forwarding tap stay quiet while reset is held.
    assign wen_eff = (rf_wen_memwb | jal_memwb) & ~nop_lw_memwb
                   & (waddr_eff != 4'd0) & rst_n;

    assign fwd_valid = wen_eff;
    assign fwd_addr  = waddr_eff;
    assign fwd_data  = wb_data;

    // Bypass is selected only under wen_eff, so X on unused data inputs never reaches a read port.
    function automatic logic [DW-1:0] read_port(input logic [3:0] addr,
                                                input logic [DW-1:0] stored);
        if (addr == 4'd0)
            return '0;
        else if (wen_eff && (waddr_eff == addr))
            return wb_data;
        else
            return stored;
    endfunction

    assign rdata1 = read_port(raddr1, regs[raddr1]);
    assign rdata2 = read_port(raddr2, regs[raddr2]);

    // NOTE: the array is reset element-by-element so every register reads zero after reset;
    // this keeps it in flops rather than letting it map onto a RAM macro without reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            wb_count <= 16'h0000;
        end else if (wen_eff) begin
            regs[waddr_eff] <= wb_data;
            wb_count        <= wb_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes expectations from a spec-level model,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rf_wen_memwb, mem2reg_memwb, s7_memwb, jal_memwb, nop_lw_memwb;
    logic [3:0]  rf_waddr_memwb, raddr1, raddr2;
    logic [15:0] aluout_memwb, extended_memwb, pc_added_memwb, mem_rdata;
    logic [15:0] rdata1, rdata2, fwd_data, wb_count;
    logic        fwd_valid;
    logic [3:0]  fwd_addr;

    wb_regfile #(.NREG(16), .DW(16), .LINK_REG(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .rf_wen_memwb(rf_wen_memwb), .mem2reg_memwb(mem2reg_memwb), .s7_memwb(s7_memwb),
        .jal_memwb(jal_memwb), .nop_lw_memwb(nop_lw_memwb), .rf_waddr_memwb(rf_waddr_memwb),
        .aluout_memwb(aluout_memwb), .extended_memwb(extended_memwb),
        .pc_added_memwb(pc_added_memwb), .mem_rdata(mem_rdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen, m2r, s7, jal, nop;
        logic [3:0]  waddr, ra1, ra2;
        logic [15:0] alu, ext, pc, mrd;
    } vec_t;

    typedef struct {
        logic [15:0] rd1, rd2, fd, cnt;
        logic        fv;
        logic [3:0]  fa;
        bit          chk_fd;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned model_rf[16];
    int unsigned model_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the driver queued for this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, " rdata1"},    32'(rdata1),    32'(e.rd1));
            check({e.tag, " rdata2"},    32'(rdata2),    32'(e.rd2));
            check({e.tag, " fwd_valid"}, 32'(fwd_valid), 32'(e.fv));
            check({e.tag, " fwd_addr"},  32'(fwd_addr),  32'(e.fa));
            check({e.tag, " wb_count"},  32'(wb_count),  32'(e.cnt));
            if (e.chk_fd)
                check({e.tag, " fwd_data"}, 32'(fwd_data), 32'(e.fd));
        end
    end

    task automatic drive(input vec_t v, input string tag, input bit xdata = 1'b0);
        exp_t        e;
        int unsigned dst, val;
        bit          en;
        @(posedge clk);
        #1;
        rf_wen_memwb   = v.wen;
        mem2reg_memwb  = v.m2r;
        s7_memwb       = v.s7;
        jal_memwb      = v.jal;
        nop_lw_memwb   = v.nop;
        rf_waddr_memwb = v.waddr;
        raddr1         = v.ra1;
        raddr2         = v.ra2;
        aluout_memwb   = xdata ? 16'hxxxx : v.alu;
        extended_memwb = xdata ? 16'hxxxx : v.ext;
        pc_added_memwb = xdata ? 16'hxxxx : v.pc;
        mem_rdata      = xdata ? 16'hxxxx : v.mrd;

        dst = v.jal ? 15 : int'(v.waddr);
        val = v.jal ? int'(v.pc) : v.m2r ? int'(v.mrd) : v.s7 ? int'(v.ext) : int'(v.alu);
        en  = (v.wen || v.jal) && !v.nop && dst != 0;

        e.rd1    = (v.ra1 == 0) ? 16'h0 : (en && dst == v.ra1) ? 16'(val) : 16'(model_rf[v.ra1]);
        e.rd2    = (v.ra2 == 0) ? 16'h0 : (en && dst == v.ra2) ? 16'(val) : 16'(model_rf[v.ra2]);
        e.fv     = en;
        e.fa     = 4'(dst);
        e.fd     = 16'(val);
        e.cnt    = 16'(model_cnt);
        e.chk_fd = !xdata;
        e.tag    = tag;
        sb.push_back(e);

        if (en) begin
            model_rf[dst] = val;
            model_cnt     = (model_cnt + 1) % 65536;
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.wen   = $urandom_range(0, 9) < 7;
        v.m2r   = $urandom_range(0, 1) == 1;
        v.s7    = $urandom_range(0, 1) == 1;
        v.jal   = $urandom_range(0, 9) == 0;
        v.nop   = $urandom_range(0, 9) == 0;
        v.waddr = 4'($urandom_range(0, 15));
        v.ra1   = 4'($urandom_range(0, 15));
        v.ra2   = 4'($urandom_range(0, 15));
        v.alu   = 16'($urandom);
        v.ext   = 16'($urandom);
        v.pc    = 16'($urandom);
        v.mrd   = 16'($urandom);
        if ($urandom_range(0, 2) == 0)
            v.ra1 = v.jal ? 4'd15 : v.waddr;
        return v;
    endfunction

    // Asserts reset mid-cycle with a live write request and checks the outputs immediately.
    task automatic reset_check(input string tag);
        @(posedge clk);
        #2;
        rf_wen_memwb = 1'b1; nop_lw_memwb = 1'b0; jal_memwb = 1'b0;
        rf_waddr_memwb = 4'd7; aluout_memwb = 16'h7777;
        mem2reg_memwb = 1'b0; s7_memwb = 1'b0;
        rst_n = 1'b0;
        #1;
        check({tag, " fwd_valid"}, 32'(fwd_valid), 32'd0);
        check({tag, " wb_count"},  32'(wb_count),  32'd0);
        for (int i = 0; i < 16; i++) begin
            raddr1 = 4'(i);
            raddr2 = 4'(15 - i);
            #1;
            check($sformatf("%s r%0d", tag, i), 32'(rdata1), 32'd0);
            check($sformatf("%s r%0d", tag, 15 - i), 32'(rdata2), 32'd0);
        end
        rf_wen_memwb = 1'b0;
        for (int i = 0; i < 16; i++)
            model_rf[i] = 0;
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        vec_t idle;
        idle = '0;
        {rf_wen_memwb, mem2reg_memwb, s7_memwb, jal_memwb, nop_lw_memwb} = '0;
        {rf_waddr_memwb, raddr1, raddr2} = '0;
        {aluout_memwb, extended_memwb, pc_added_memwb, mem_rdata} = '0;
        for (int i = 0; i < 16; i++)
            model_rf[i] = 0;
        model_cnt = 0;

        reset_check("init_reset");

        v = idle; v.wen = 1; v.waddr = 4'd3; v.alu = 16'h1234; v.ra1 = 4'd3;
        drive(v, "alu_bypass");
        v = idle; v.ra1 = 4'd3; v.ra2 = 4'd3;
        drive(v, "alu_stored");

        v = idle; v.wen = 1; v.m2r = 1; v.s7 = 1; v.mrd = 16'hBEEF; v.ext = 16'h00AA;
        v.alu = 16'h1111; v.waddr = 4'd5; v.ra1 = 4'd5;
        drive(v, "mem_over_s7");
        v = idle; v.ra1 = 4'd5;
        drive(v, "mem_stored");

        v = idle; v.jal = 1; v.m2r = 1; v.pc = 16'h0042; v.mrd = 16'hDEAD;
        v.waddr = 4'd2; v.ra1 = 4'd15; v.ra2 = 4'd2;
        drive(v, "jal_over_mem");
        v = idle; v.ra1 = 4'd15; v.ra2 = 4'd2;
        drive(v, "jal_stored");

        v = idle; v.wen = 1; v.nop = 1; v.waddr = 4'd4; v.alu = 16'hFFFF; v.ra1 = 4'd4;
        drive(v, "nop_lw_block");
        v = idle; v.ra1 = 4'd4;
        drive(v, "nop_lw_after");

        v = idle; v.wen = 1; v.waddr = 4'd0; v.alu = 16'h5555; v.ra1 = 4'd0; v.ra2 = 4'd0;
        drive(v, "r0_write");
        v = idle; v.ra1 = 4'd0; v.ra2 = 4'd3;
        drive(v, "r0_after");

        v = idle; v.ra1 = 4'd3; v.ra2 = 4'd5;
        drive(v, "x_data_idle", 1'b1);

        v = idle; v.wen = 1; v.waddr = 4'd9; v.alu = 16'hA5A5; v.ra1 = 4'd9; v.ra2 = 4'd9;
        drive(v, "same_addr_reads");

        reset_check("mid_reset");
        v = idle; v.wen = 1; v.waddr = 4'd6; v.alu = 16'h0606; v.ra1 = 4'd6; v.ra2 = 4'd3;
        drive(v, "post_reset_commit");

        for (int n = 0; n < 10000; n++)
            drive(rand_vec(), "random");

        // Walk the counter up to 0xFFFF, then one more commit must wrap it.
        while (model_cnt != 32'hFFFF) begin
            v = rand_vec();
            v.wen = 1; v.nop = 0; v.jal = 0;
            if (v.waddr == 4'd0) v.waddr = 4'd1;
            drive(v, "fill");
        end
        v = idle; v.wen = 1; v.waddr = 4'd8; v.alu = 16'hFFFF; v.ra1 = 4'd8;
        drive(v, "wrap_commit");
        v = idle; v.ra1 = 4'd8;
        drive(v, "wrap_after");

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
